// File: rtl/neuron_layer_sched.sv
// neuron_layer_sched: one shared 3-input MAC + ReLU datapath, time-multiplexed
// across N_NEURONS logical neurons. Per-neuron weights/bias live in lane
// register instances written through the cfg port; each accepted input vector
// produces N_NEURONS results in index order on a valid/ready stream.
// Build option: define NEURON_SCHED_SAT_EN for saturating products/accumulates
// instead of modulo-2**32 wrap-around (latency is the same either way).

package neuron_layer_sched_pkg;

    // Stored parameters of one logical neuron.
    typedef struct packed {
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
        logic [31:0] bias;
    } nrn_cfg_t;

    // Write request as seen by a single lane (we already qualified by index).
    typedef struct packed {
        logic        we;
        logic [1:0]  sel;
        logic [31:0] data;
    } cfg_req_t;

endpackage

// Register file slice for one neuron.
module neuron_layer_sched_lane
    import neuron_layer_sched_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  cfg_req_t req,
    output nrn_cfg_t cfg
);

    // Field write; the parent only raises we for the addressed, accepted write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg <= '0;
        end else if (req.we) begin
            case (req.sel)
                2'd0:    cfg.w1   <= req.data;
                2'd1:    cfg.w2   <= req.data;
                2'd2:    cfg.w3   <= req.data;
                default: cfg.bias <= req.data;
            endcase
        end
    end

endmodule

module neuron_layer_sched
    import neuron_layer_sched_pkg::*;
#(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [1:0]       cfg_sel,
    input  logic [31:0]      cfg_data,
    output logic             cfg_drop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in1,
    input  logic [31:0]      in2,
    input  logic [31:0]      in3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, ACT, HOLD} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        n;
    logic [IDX_W-1:0]        n_inc;
    logic                    n_is_last;
    logic [31:0]             acc;
    logic [31:0]             acc_nxt;
    logic [31:0]             in1_q, in2_q, in3_q;
    logic [31:0]             cur_w1, cur_w2, cur_w3;
    logic [31:0]             nxt_bias;
    logic [31:0]             mac_w, mac_x;
    logic                    accept;
    logic                    idx_ok;
    logic                    cfg_ok;
    nrn_cfg_t [N_NEURONS-1:0] lane_cfg;

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign n_inc     = n + IDX_W'(1);
    assign n_is_last = (n == IDX_W'(N_NEURONS - 1));

    // A write lands only while idle, with no competing accept, to a real neuron.
    assign idx_ok = (32'(cfg_idx) < 32'(N_NEURONS));
    assign cfg_ok = cfg_we && in_ready && !in_valid && idx_ok;

    for (genvar i = 0; i < N_NEURONS; i++) begin : g_lane
        cfg_req_t req;
        assign req.we   = cfg_ok && (cfg_idx == IDX_W'(i));
        assign req.sel  = cfg_sel;
        assign req.data = cfg_data;

        neuron_layer_sched_lane u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (req),
            .cfg   (lane_cfg[i])
        );
    end

    // Weight read for the current neuron and bias preload for the next one.
    always_comb begin
        cur_w1   = '0;
        cur_w2   = '0;
        cur_w3   = '0;
        nxt_bias = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (n == IDX_W'(i)) begin
                cur_w1 = lane_cfg[i].w1;
                cur_w2 = lane_cfg[i].w2;
                cur_w3 = lane_cfg[i].w3;
            end
            if (n_inc == IDX_W'(i)) begin
                nxt_bias = lane_cfg[i].bias;
            end
        end
    end

    // Operand pair for the MAC step selected by the current state.
    always_comb begin
        mac_w = cur_w1;
        mac_x = in1_q;
        case (state)
            MAC1: begin
                mac_w = cur_w2;
                mac_x = in2_q;
            end
            MAC2: begin
                mac_w = cur_w3;
                mac_x = in3_q;
            end
            default: ;
        endcase
    end

`ifdef NEURON_SCHED_SAT_EN
    logic [63:0] prod_full;
    logic [31:0] prod_sat;
    logic [32:0] sum_ext;

    // Full-width signed product and sum, both clamped to the signed 32-bit range.
    always_comb begin
        prod_full = {{32{mac_w[31]}}, mac_w} * {{32{mac_x[31]}}, mac_x};
        if (prod_full[63:31] != {33{prod_full[63]}}) begin
            prod_sat = prod_full[63] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            prod_sat = prod_full[31:0];
        end
        sum_ext = {acc[31], acc} + {prod_sat[31], prod_sat};
        if (sum_ext[32] != sum_ext[31]) begin
            acc_nxt = sum_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            acc_nxt = sum_ext[31:0];
        end
    end
`else
    logic [31:0] prod_lo;

    // Low 32 bits of the product are identical for signed and unsigned operands.
    always_comb begin
        prod_lo = mac_w * mac_x;
        acc_nxt = acc + prod_lo;
    end
`endif

    // Scheduler FSM: bias preload, three MAC cycles, ReLU, then hold for the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            acc       <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
            in3_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        in1_q <= in1;
                        in2_q <= in2;
                        in3_q <= in3;
                        n     <= '0;
                        acc   <= lane_cfg[0].bias;
                        state <= MAC0;
                    end
                end
                MAC0: begin
                    acc   <= acc_nxt;
                    state <= MAC1;
                end
                MAC1: begin
                    acc   <= acc_nxt;
                    state <= MAC2;
                end
                MAC2: begin
                    acc   <= acc_nxt;
                    state <= ACT;
                end
                ACT: begin
                    out_data  <= acc[31] ? 32'd0 : acc;
                    out_idx   <= n;
                    out_last  <= n_is_last;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (n_is_last) begin
                            state <= IDLE;
                        end else begin
                            n     <= n_inc;
                            acc   <= nxt_bias;
                            state <= MAC0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One-cycle flag for every write strobe that did not land.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_drop <= 1'b0;
        end else begin
            cfg_drop <= cfg_we && !cfg_ok;
        end
    end

endmodule
